// File: rtl/bench_pkg.sv
// Shared state encoding, FIFO command codes and error codes for the
// DDR benchmark run sequencer.
package bench_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD_START, ST_LAUNCH, ST_WAIT_DONE, ST_CMD_STOP, ST_COLLECT
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_ABORT = 2'b10;

    // States in which the per-iteration watchdog advances.
    function automatic logic is_watched(input state_t s);
        return (s == ST_LAUNCH) || (s == ST_WAIT_DONE) ||
               (s == ST_CMD_STOP) || (s == ST_COLLECT);
    endfunction
endpackage

// File: rtl/bench_stat_accum.sv
// Running min / max / saturating sum over cycle-count results.
module bench_stat_accum #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] stat_min,
    output logic [CNT_W-1:0] stat_max,
    output logic [CNT_W-1:0] stat_sum
);
    logic [CNT_W:0] sum_wide;

    assign sum_wide = {1'b0, stat_sum} + {1'b0, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_min <= '1;
            stat_max <= '0;
            stat_sum <= '0;
        end else if (clr) begin
            stat_min <= '1;
            stat_max <= '0;
            stat_sum <= '0;
        end else if (vld) begin
            if (din < stat_min) stat_min <= din;
            if (din > stat_max) stat_max <= din;
            stat_sum <= sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/bench_run_sequencer.sv
// Repeats the benchmark dataflow region N times, bracketing each run with
// counter START/STOP commands and folding the results into statistics.
module bench_run_sequencer
    import bench_pkg::*;
#(
    parameter int ITER_W = 16,
    parameter int CNT_W  = 64,
    parameter int TMO_W  = 32
) (
    input  logic              dl_clock,
    input  logic              dl_reset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ITER_W-1:0] cfg_iters,
    input  logic [TMO_W-1:0]  cfg_timeout,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    output logic              ap_continue,
    output logic [1:0]        cmd_din,
    output logic              cmd_write,
    input  logic              cmd_full_n,
    input  logic [CNT_W-1:0]  res_dout,
    input  logic              res_empty_n,
    output logic              res_read,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [CNT_W-1:0]  stat_sum
);
    state_t            state, state_nxt;
    logic [ITER_W-1:0] iters_q, iter_inc;
    logic [TMO_W-1:0]  tmo_q, wd_cnt;
    logic              start_ok, fin_zero, rd_fire, wd_hit;
    logic              fin_ok, fin_tmo, fin_abort;
    logic              cmd_req, rd_req;
    logic              start_nxt, cont_nxt, busy_nxt, cmd_req_nxt, rd_req_nxt;
    logic [1:0]        cmd_din_nxt;

    assign start_ok  = (state == ST_IDLE) && cfg_start;
    assign fin_zero  = start_ok && (cfg_iters == '0);
    assign iter_inc  = iter_cnt + ITER_W'(1);
    assign cmd_write = cmd_req && cmd_full_n;
    assign res_read  = rd_req && res_empty_n;
    assign rd_fire   = res_read;
    // Firing on count tmo-1 makes done appear exactly tmo cycles after LAUNCH entry.
    assign wd_hit    = (tmo_q != '0) && is_watched(state) && (wd_cnt == tmo_q - TMO_W'(1));

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin_ok    = 1'b0;
        fin_tmo   = 1'b0;
        fin_abort = 1'b0;
        case (state)
            ST_IDLE:      if (cfg_start && cfg_iters != '0) state_nxt = ST_CMD_START;
            ST_CMD_START: if (cmd_full_n) state_nxt = ST_LAUNCH;
            ST_LAUNCH:    if (ap_ready) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (ap_done) state_nxt = ST_CMD_STOP;
            ST_CMD_STOP:  if (cmd_full_n) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (rd_fire) begin
                    fin_ok    = (iter_inc == iters_q);
                    state_nxt = fin_ok ? ST_IDLE : ST_CMD_START;
                end
            end
            default:      state_nxt = ST_IDLE;
        endcase
        // Abort beats timeout, which beats completion.
        if (state != ST_IDLE && cfg_abort) begin
            state_nxt = ST_IDLE;
            fin_abort = 1'b1;
            fin_ok    = 1'b0;
        end else if (wd_hit) begin
            state_nxt = ST_IDLE;
            fin_tmo   = 1'b1;
            fin_ok    = 1'b0;
        end
    end

    always_comb begin
        start_nxt   = (state_nxt == ST_LAUNCH);
        cont_nxt    = (state_nxt == ST_WAIT_DONE);
        busy_nxt    = (state_nxt != ST_IDLE);
        rd_req_nxt  = (state_nxt == ST_COLLECT);
        cmd_req_nxt = (state_nxt == ST_CMD_START) || (state_nxt == ST_CMD_STOP);
        cmd_din_nxt = (state_nxt == ST_CMD_START) ? CMD_START :
                      (state_nxt == ST_CMD_STOP)  ? CMD_STOP  : CMD_NONE;
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            busy        <= 1'b0;
            rd_req      <= 1'b0;
            cmd_req     <= 1'b0;
            cmd_din     <= CMD_NONE;
            done        <= 1'b0;
        end else begin
            ap_start    <= start_nxt;
            ap_continue <= cont_nxt;
            busy        <= busy_nxt;
            rd_req      <= rd_req_nxt;
            cmd_req     <= cmd_req_nxt;
            cmd_din     <= cmd_din_nxt;
            done        <= fin_ok || fin_tmo || fin_abort || fin_zero;
        end
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            iters_q  <= '0;
            tmo_q    <= '0;
            wd_cnt   <= '0;
            iter_cnt <= '0;
            err_code <= ERR_OK;
        end else begin
            if (start_ok) begin
                iters_q  <= cfg_iters;
                tmo_q    <= cfg_timeout;
                iter_cnt <= '0;
                err_code <= ERR_OK;
            end else if (rd_fire) begin
                iter_cnt <= iter_inc;
            end
            if (fin_abort)    err_code <= ERR_ABORT;
            else if (fin_tmo) err_code <= ERR_TMO;
            if (state_nxt == ST_LAUNCH && state != ST_LAUNCH) wd_cnt <= '0;
            else if (is_watched(state) && wd_cnt != '1)        wd_cnt <= wd_cnt + TMO_W'(1);
        end
    end

    bench_stat_accum #(.CNT_W(CNT_W)) u_stat (
        .clk      (dl_clock),
        .rst_n    (dl_reset),
        .clr      (start_ok),
        .vld      (rd_fire),
        .din      (res_dout),
        .stat_min (stat_min),
        .stat_max (stat_max),
        .stat_sum (stat_sum)
    );
endmodule

// File: tb/tb_bench_run_sequencer.sv
// Bench for bench_run_sequencer: behavioural region / FIFO models plus a
// result-list statistics model; directed steps with randomized data.
module tb_bench_run_sequencer;
    logic        dl_clock, dl_reset;
    logic        cfg_start, cfg_abort;
    logic [15:0] cfg_iters;
    logic [31:0] cfg_timeout;
    logic        ap_start, ap_ready, ap_done, ap_continue;
    logic [1:0]  cmd_din;
    logic        cmd_write, cmd_full_n;
    logic [63:0] res_dout;
    logic        res_empty_n, res_read;
    logic        busy, done;
    logic [1:0]  err_code;
    logic [15:0] iter_cnt;
    logic [63:0] stat_min, stat_max, stat_sum;

    bench_run_sequencer dut (
        .dl_clock(dl_clock), .dl_reset(dl_reset),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_iters(cfg_iters), .cfg_timeout(cfg_timeout),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue),
        .cmd_din(cmd_din), .cmd_write(cmd_write), .cmd_full_n(cmd_full_n),
        .res_dout(res_dout), .res_empty_n(res_empty_n), .res_read(res_read),
        .busy(busy), .done(done), .err_code(err_code), .iter_cnt(iter_cnt),
        .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
    );

    initial dl_clock = 1'b0;
    always #5 dl_clock = ~dl_clock;

    // Environment state: region model, result FIFO contents, monitors.
    logic [63:0] res_arr [16];
    logic [4:0]  res_idx   = '0;
    int          res_n     = 0;
    int          lat       = 0;
    int          lat_cnt   = -1;
    int          full_cnt  = 0;
    int          res_hold  = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;
    int          busy_cnt  = 0;
    int          qual_bad  = 0;
    int          done_at   = 0;
    int          rise_at   = 0;
    bit          rdy_ok    = 1'b1;
    bit          rand_rdy  = 1'b0;
    bit          done_en   = 1'b1;
    bit          stall_en  = 1'b0;
    bit          res_en    = 1'b1;
    bit          flush     = 1'b0;
    bit          prev_start = 1'b0;
    logic [1:0]  cmd_log [$];
    int          total = 0;
    int          bad   = 0;

    assign ap_ready    = ap_start && rdy_ok;
    assign cmd_full_n  = (full_cnt == 0);
    assign res_empty_n = res_en && (res_hold == 0) && (int'(res_idx) < res_n);
    assign res_dout    = res_arr[res_idx[3:0]];

    always begin : env
        bit s_acc, s_cont, s_rd, s_stop;
        @(negedge dl_clock);
        s_acc  = ap_start && ap_ready;
        s_cont = ap_done && ap_continue;
        s_rd   = res_read;
        s_stop = cmd_write && (cmd_din == 2'b10);
        if (cmd_write) cmd_log.push_back(cmd_din);
        if ((cmd_write && !cmd_full_n) || (res_read && !res_empty_n)) qual_bad++;
        if (done) begin done_cnt++; done_at = cyc; end
        if (busy) busy_cnt++;
        if (ap_start && !prev_start) rise_at = cyc;
        prev_start = ap_start;
        @(posedge dl_clock);
        cyc++;
        #1;
        if (flush) begin
            res_idx = '0; ap_done = 1'b0; lat_cnt = -1;
            full_cnt = 0; res_hold = 0; cmd_log.delete();
        end else begin
            if (s_rd) res_idx = res_idx + 5'd1;
            if (s_cont) ap_done = 1'b0;
            if (s_acc) lat_cnt = lat;
            if (lat_cnt == 0 && done_en) begin ap_done = 1'b1; lat_cnt = -1; end
            else if (lat_cnt > 0) lat_cnt--;
            if (stall_en && s_cont) full_cnt = 10; else if (full_cnt > 0) full_cnt--;
            if (stall_en && s_stop) res_hold = 5;  else if (res_hold > 0) res_hold--;
        end
        rdy_ok = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge dl_clock); #1; end
    endtask

    task automatic flush_env();
        flush = 1'b1; tick(2); flush = 1'b0;
    endtask

    task automatic start_run(input int iters, input int tmo, output int c);
        cfg_iters = 16'(iters); cfg_timeout = 32'(tmo); cfg_start = 1'b1;
        c = cyc;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int max_cyc);
        int i;
        i = 0;
        while (done_cnt == base && i < max_cyc) begin tick(); i++; end
        chk({tag, "_done_seen"}, 64'(done_cnt != base), 64'd1);
    endtask

    // Statistics of the first n results, from the list itself.
    function automatic void model(input int n, output logic [63:0] mn,
                                  output logic [63:0] mx, output logic [63:0] sm);
        logic [71:0] tot;
        tot = '0; mn = '1; mx = '0;
        for (int i = 0; i < n; i++) begin
            if (res_arr[i] < mn) mn = res_arr[i];
            if (res_arr[i] > mx) mx = res_arr[i];
            tot = tot + 72'(res_arr[i]);
        end
        sm = (tot > 72'({64{1'b1}})) ? '1 : tot[63:0];
    endfunction

    task automatic check_stats(input string tag, input int n);
        logic [63:0] mn, mx, sm;
        model(n, mn, mx, sm);
        chk({tag, "_min"}, stat_min, mn);
        chk({tag, "_max"}, stat_max, mx);
        chk({tag, "_sum"}, stat_sum, sm);
        chk({tag, "_iter"}, 64'(iter_cnt), 64'(n));
    endtask

    task automatic check_cmds(input string tag, input int n);
        int sz;
        sz = cmd_log.size();
        chk({tag, "_cmd_count"}, 64'(sz), 64'(2 * n));
        for (int i = 0; i < sz && i < 2 * n; i++)
            chk({tag, "_cmd_order"}, 64'(cmd_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err_code), 64'd0);
        chk({tag, "_iter"}, 64'(iter_cnt), 64'd0);
        chk({tag, "_min"}, stat_min, {64{1'b1}});
        chk({tag, "_max"}, stat_max, 64'd0);
        chk({tag, "_sum"}, stat_sum, 64'd0);
        chk({tag, "_ap_start"}, 64'(ap_start), 64'd0);
        chk({tag, "_ap_cont"}, 64'(ap_continue), 64'd0);
        chk({tag, "_cmd_write"}, 64'(cmd_write), 64'd0);
        chk({tag, "_res_read"}, 64'(res_read), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int c, base, b, n, i;
        int tmos [2];
        dl_reset = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_iters = '0; cfg_timeout = '0;
        for (int k = 0; k < 16; k++) res_arr[k] = '0;
        tick(3);
        check_reset_vals("reset");
        dl_reset = 1'b1;
        tick(2);

        // Three iterations with fixed results.
        res_arr[0] = 64'd100; res_arr[1] = 64'd80; res_arr[2] = 64'd120; res_n = 3;
        flush_env();
        base = done_cnt;
        start_run(3, 0, c);
        wait_done("basic", base, 300);
        check_cmds("basic", 3);
        chk("basic_err", 64'(err_code), 64'd0);
        check_stats("basic", 3);
        chk("basic_sum_lit", stat_sum, 64'd300);
        tick(3);
        chk("basic_done_width", 64'(done_cnt - base), 64'd1);

        // Zero iterations: done one cycle later, never busy.
        flush_env();
        base = done_cnt; b = busy_cnt;
        start_run(0, 0, c);
        tick(3);
        chk("zero_done_cnt", 64'(done_cnt - base), 64'd1);
        chk("zero_done_cycle", 64'(done_at), 64'(c + 1));
        chk("zero_busy", 64'(busy_cnt - b), 64'd0);
        check_reset_vals("zero");

        // Randomized runs with random ready / done latency.
        rand_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) res_arr[k] = {$urandom, $urandom} >> $urandom_range(0, 40);
            res_n = n; lat = $urandom_range(0, 3);
            flush_env();
            base = done_cnt;
            start_run(n, (r % 2 == 1) ? 0 : 1000, c);
            wait_done("rand", base, 500);
            check_cmds("rand", n);
            chk("rand_err", 64'(err_code), 64'd0);
            check_stats("rand", n);
        end
        rand_rdy = 1'b0;

        // Back-pressure on STOP and delayed result.
        stall_en = 1'b1; lat = 1;
        for (int k = 0; k < 2; k++) res_arr[k] = 64'($urandom_range(1, 100000));
        res_n = 2;
        flush_env();
        base = done_cnt; b = qual_bad;
        start_run(2, 0, c);
        wait_done("stall", base, 500);
        check_cmds("stall", 2);
        chk("stall_err", 64'(err_code), 64'd0);
        check_stats("stall", 2);
        chk("stall_cycles_min", 64'(done_at - c >= 30), 64'd1);
        chk("stall_qualifier", 64'(qual_bad - b), 64'd0);
        stall_en = 1'b0;

        // Watchdog: region never finishes.
        done_en = 1'b0; res_n = 0;
        tmos[0] = 50; tmos[1] = $urandom_range(3, 40);
        for (int t = 0; t < 2; t++) begin
            flush_env();
            base = done_cnt;
            start_run(1, tmos[t], c);
            wait_done("tmo", base, 300);
            chk("tmo_latency", 64'(done_at - rise_at), 64'(tmos[t]));
            chk("tmo_err", 64'(err_code), 64'd1);
            chk("tmo_iter", 64'(iter_cnt), 64'd0);
            chk("tmo_ap_cont", 64'(ap_continue), 64'd0);
            chk("tmo_busy", 64'(busy), 64'd0);
        end
        done_en = 1'b1;

        // Abort during WAIT_DONE of iteration 2.
        for (int k = 0; k < 4; k++) res_arr[k] = 64'($urandom_range(1, 1000000));
        res_n = 4; lat = 8;
        flush_env();
        base = done_cnt;
        start_run(4, 0, c);
        i = 0;
        while (!(cmd_log.size() == 3 && ap_continue) && i < 200) begin tick(); i++; end
        chk("abort_reach_wait", 64'(cmd_log.size() == 3 && ap_continue), 64'd1);
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
        wait_done("abort", base, 50);
        chk("abort_err", 64'(err_code), 64'd2);
        check_stats("abort", 1);
        chk("abort_ap_cont", 64'(ap_continue), 64'd0);
        flush_env();
        start_run(0, 0, c);
        tick(2);
        check_reset_vals("restart");

        // Saturating sum.
        res_arr[0] = {64{1'b1}}; res_arr[1] = 64'd5; res_n = 2; lat = 0;
        flush_env();
        base = done_cnt;
        start_run(2, 0, c);
        wait_done("sat", base, 200);
        check_stats("sat", 2);
        chk("sat_sum_lit", stat_sum, {64{1'b1}});

        // Asynchronous reset while stuck in COLLECT of iteration 2.
        res_arr[0] = 64'($urandom_range(1, 5000)); res_n = 1;
        flush_env();
        start_run(2, 0, c);
        i = 0;
        while (cmd_log.size() < 4 && i < 200) begin tick(); i++; end
        tick(2);
        chk("arst_pre_busy", 64'(busy), 64'd1);
        chk("arst_pre_iter", 64'(iter_cnt), 64'd1);
        #3;
        dl_reset = 1'b0;
        #1;
        check_reset_vals("arst");
        tick();
        dl_reset = 1'b1;
        tick(2);

        chk("qualifier_total", 64'(qual_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
